// File: rtl/hc_adder_pkg.sv
// Shared types and constants for the serial
// Han-Carlson add controller.
package hc_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/hc_adder_slice.sv
// 4-bit Han-Carlson prefix adder slice.
// Carry-in is folded in as the generate of bit -1.
module hc_adder_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g0c;
  logic       g10;
  logic       g32;
  logic       p32;
  logic       g30;
  logic       g20;

  assign g   = a & b;
  assign p   = a ^ b;

  // bit 0 absorbs cin, so its group covers [0:-1]
  assign g0c = g[0] | (p[0] & cin);

  // odd bits combine with their even neighbour
  assign g10 = g[1] | (p[1] & g0c);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];

  // odd bits reach across the full span
  assign g30 = g32 | (p32 & g10);

  // even bits pick up the odd prefix below them
  assign g20 = g[2] | (p[2] & g10);

  assign sum  = p ^ {g20, g10, g0c, cin};
  assign cout = g30;

endmodule

// File: rtl/hc_serial_add_ctrl.sv
// Round-robin arbiter and nibble-serial sequencer
// sharing one Han-Carlson slice between two requesters.
module hc_serial_add_ctrl
  import hc_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
    $error("hc_serial_add_ctrl: WIDTH must be a multiple of 4, >= 4");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  req_id_t          id_q;
  req_id_t          prio_q;
  req_id_t          grant;
  logic             accept;
  logic             last;
  logic             done_hs;
  logic [3:0]       s_nib;
  logic             s_cout;

  hc_adder_slice u_slice (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (s_nib),
    .cout (s_cout)
  );

  // priority holder wins; otherwise the other one
  always_comb begin
    grant = ~prio_q;
    if (req_valid[prio_q])
      grant = prio_q;
  end

  assign accept    = (state == IDLE) && req_valid[grant];
  assign last      = (cnt_q == CW'(N - 1));
  assign done_hs   = (state == DONE) && rsp_ready;
  assign req_ready = accept ? (2'b01 << grant) : 2'b00;
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): if (accept)  state_nxt = RUN;
      (state == RUN):  if (last)    state_nxt = DONE;
      (state == DONE): if (done_hs) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // operand capture, nibble stepping and result hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= grant ? req_a1 : req_a0;
        b_q     <= grant ? req_b1 : req_b0;
        carry_q <= 1'b0;
        cnt_q   <= '0;
        id_q    <= grant;
      end
      if (state == RUN) begin
        a_q     <= a_q >> NIBBLE;
        b_q     <= b_q >> NIBBLE;
        sum_q   <= (sum_q >> NIBBLE)
                 | (WIDTH'(s_nib) << (WIDTH - NIBBLE));
        carry_q <= s_cout;
        cnt_q   <= cnt_q + CW'(1);
        if (last)
          cout_q <= s_cout;
      end
      if (done_hs)
        prio_q <= ~id_q;
    end
  end

endmodule

// File: tb/tb_hc_serial_add_ctrl.sv
// Directed bench for hc_serial_add_ctrl:
// WIDTH=16 instance plus a WIDTH=4 instance.
module tb_hc_serial_add_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_cout, rsp_id, busy;

  logic        rst4;
  logic [1:0]  req_valid4;
  logic [1:0]  req_ready4;
  logic [3:0]  a4_0, b4_0, a4_1, b4_1;
  logic        rsp_valid4, rsp_ready4;
  logic [3:0]  rsp_sum4;
  logic        rsp_cout4, rsp_id4, busy4;

  int checks = 0;
  int fails  = 0;

  hc_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  hc_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a0(a4_0), .req_b0(b4_0),
    .req_a1(a4_1), .req_b1(b4_1),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_sum(rsp_sum4), .rsp_cout(rsp_cout4),
    .rsp_id(rsp_id4), .busy(busy4)
  );

  // Drives one request (rsp_ready assumed high) and
  // returns what was observed; callers do the checks.
  task automatic do_op(input logic g,
                       input logic [15:0] a, b,
                       output int lat,
                       output logic [15:0] s,
                       output logic c, id, to);
    int w;
    to = 1'b0;
    if (g) begin req_a1 = a; req_b1 = b; end
    else   begin req_a0 = a; req_b0 = b; end
    req_valid[g] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[g] && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready[g]) to = 1'b1;
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) to = 1'b1;
    s  = rsp_sum;
    c  = rsp_cout;
    id = rsp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst4 = 1'b1;
    req_valid = 2'b00; req_valid4 = 2'b00;
    rsp_ready = 1'b1; rsp_ready4 = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    a4_0 = '0; b4_0 = '0; a4_1 = '0; b4_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin fails++;
      $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++;
      $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_sum !== 16'h0) begin fails++;
      $display("FAIL reset_rsp_sum got=%h exp=0000", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin fails++;
      $display("FAIL reset_rsp_cout got=%b exp=0", rsp_cout); end
    checks++; if (rsp_id !== 1'b0) begin fails++;
      $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat; logic [15:0] s; logic c, id, to;
    do_op(1'b0, 16'h1234, 16'h4321, lat, s, c, id, to);
    checks++; if (to !== 1'b0) begin fails++;
      $display("FAIL basic_timeout got=%b exp=0", to); end
    checks++; if (lat != 5) begin fails++;
      $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++; if (s !== 16'h5555) begin fails++;
      $display("FAIL basic_sum got=%h exp=5555", s); end
    checks++; if (c !== 1'b0) begin fails++;
      $display("FAIL basic_cout got=%b exp=0", c); end
    checks++; if (id !== 1'b0) begin fails++;
      $display("FAIL basic_id got=%b exp=0", id); end
  endtask

  task automatic test_carry;
    int lat; logic [15:0] s; logic c, id, to;
    do_op(1'b1, 16'hFFFF, 16'h0001, lat, s, c, id, to);
    checks++; if (to !== 1'b0) begin fails++;
      $display("FAIL carry_timeout got=%b exp=0", to); end
    checks++; if (s !== 16'h0000) begin fails++;
      $display("FAIL carry_sum got=%h exp=0000", s); end
    checks++; if (c !== 1'b1) begin fails++;
      $display("FAIL carry_cout got=%b exp=1", c); end
    checks++; if (id !== 1'b1) begin fails++;
      $display("FAIL carry_id got=%b exp=1", id); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_s [2];
    logic        exp_c [2];
    int w;
    logic eid;
    exp_s[0] = 16'h3333; exp_c[0] = 1'b0;
    exp_s[1] = 16'h0001; exp_c[1] = 1'b1;
    req_a0 = 16'h1111; req_b0 = 16'h2222;
    req_a1 = 16'h8000; req_b1 = 16'h8001;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      eid = (k % 2 == 1);
      w = 0;
      while (!rsp_valid && w < 20) begin
        @(posedge clk); #1; w++;
      end
      checks++; if (rsp_valid !== 1'b1) begin fails++;
        $display("FAIL b2b_timeout k=%0d got=%b exp=1", k, rsp_valid); end
      checks++; if (rsp_id !== eid) begin fails++;
        $display("FAIL b2b_id k=%0d got=%b exp=%b", k, rsp_id, eid); end
      checks++; if ({rsp_cout, rsp_sum} !== {exp_c[eid], exp_s[eid]}) begin
        fails++;
        $display("FAIL b2b_sum k=%0d got=%b_%h exp=%b_%h", k,
                 rsp_cout, rsp_sum, exp_c[eid], exp_s[eid]);
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_stall;
    int w;
    rsp_ready = 1'b0;
    req_a0 = 16'h00FF; req_b0 = 16'h0F01;
    req_a1 = 16'h7FFF; req_b1 = 16'h0001;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++;
      $display("FAIL stall_grant0 got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b10;
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin fails++;
        $display("FAIL stall_valid k=%0d got=%b exp=1", k, rsp_valid); end
      checks++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b0, 1'b0, 16'h1000}) begin
        fails++;
        $display("FAIL stall_hold k=%0d got=%b_%b_%h exp=0_0_1000",
                 k, rsp_id, rsp_cout, rsp_sum);
      end
      checks++; if (req_ready !== 2'b00) begin fails++;
        $display("FAIL stall_req_ready k=%0d got=%b exp=00", k, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++;
      $display("FAIL stall_release got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 2'b10) begin fails++;
      $display("FAIL stall_pending got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    checks++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b0, 16'h8000}) begin
      fails++;
      $display("FAIL stall_second got=%b_%b_%h exp=1_0_8000",
               rsp_id, rsp_cout, rsp_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int lat; logic [15:0] s; logic c, id, to;
    logic seen;
    do_op(1'b0, 16'h0001, 16'h0001, lat, s, c, id, to);
    checks++; if ({to, s} !== {1'b0, 16'h0002}) begin fails++;
      $display("FAIL rrun_pre got=%b_%h exp=0_0002", to, s); end
    req_a1 = 16'h1234; req_b1 = 16'h1111;
    req_valid = 2'b10;
    #1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin fails++;
      $display("FAIL rrun_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({rsp_valid, busy, rsp_cout, rsp_id} !== 4'b0000) begin
      fails++;
      $display("FAIL rrun_flags got=%b%b%b%b exp=0000",
               rsp_valid, busy, rsp_cout, rsp_id);
    end
    checks++; if (rsp_sum !== 16'h0000) begin fails++;
      $display("FAIL rrun_sum got=%h exp=0000", rsp_sum); end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++;
      $display("FAIL rrun_regrant got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin fails++;
      $display("FAIL rrun_no_rsp got=%b exp=0", seen); end
  endtask

  task automatic test_width4;
    int lat;
    a4_0 = 4'h9; b4_0 = 4'h8;
    req_valid4 = 2'b01;
    #1;
    checks++; if (req_ready4 !== 2'b01) begin fails++;
      $display("FAIL w4_ready got=%b exp=01", req_ready4); end
    @(posedge clk); #1;
    req_valid4 = 2'b00;
    lat = 1;
    while (!rsp_valid4 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat != 2) begin fails++;
      $display("FAIL w4_latency got=%0d exp=2", lat); end
    checks++; if ({rsp_cout4, rsp_sum4} !== 5'b1_0001) begin fails++;
      $display("FAIL w4_sum got=%b_%h exp=1_1", rsp_cout4, rsp_sum4); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    test_width4();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
